// File: rtl/gray_frame_streamer.sv
// Frame-buffered raster source: stores one 8-bit frame and replays it as a pixel stream in raster order.
// Each pixel appears one cycle after its read is issued. hold pauses issue, and LINE_GAP idle cycles separate rows.
module gray_frame_streamer #(
    parameter  int IMAGE_WIDTH  = 320,
    parameter  int IMAGE_HEIGHT = 240,
    parameter  int LINE_GAP     = 4,
    localparam int ADDR_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              gray_valid,
    output logic [7:0]        gray,
    output logic [31:0]       pix_row,
    output logic [31:0]       pix_col
);
    localparam int DEPTH = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(IMAGE_HEIGHT);
    localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, GAP, FLUSH} state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic              issue;

    logic [7:0] mem [DEPTH];

    assign busy = (state != IDLE);

    // Raster order makes the read address a plain running count, so no row*width multiply is needed.
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        row_nxt     = row;
        rd_addr_nxt = rd_addr;
        gap_cnt_nxt = gap_cnt;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = STREAM;
                    col_nxt     = '0;
                    row_nxt     = '0;
                    rd_addr_nxt = '0;
                end
            end
            STREAM: begin
                if (!hold) begin
                    issue       = 1'b1;
                    rd_addr_nxt = rd_addr + ADDR_W'(1);
                    if (col == COL_W'(IMAGE_WIDTH - 1)) begin
                        col_nxt     = '0;
                        row_nxt     = row + ROW_W'(1);
                        gap_cnt_nxt = '0;
                        if (row == ROW_W'(IMAGE_HEIGHT - 1)) begin
                            state_nxt = FLUSH;
                        end else if (LINE_GAP > 0) begin
                            state_nxt = GAP;
                        end
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(LINE_GAP - 1)) begin
                    state_nxt = STREAM;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && 32'(wr_addr) < DEPTH) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            rd_addr    <= '0;
            gap_cnt    <= '0;
            done       <= 1'b0;
            gray_valid <= 1'b0;
            gray       <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
        end else begin
            col        <= col_nxt;
            row        <= row_nxt;
            rd_addr    <= rd_addr_nxt;
            gap_cnt    <= gap_cnt_nxt;
            done       <= (state == FLUSH);
            gray_valid <= issue;
            if (issue) begin
                gray    <= mem[rd_addr];
                pix_row <= 32'(row);
                pix_col <= 32'(col);
            end
        end
    end
endmodule

// File: tb/tb_gray_frame_streamer.sv
// Bench for gray_frame_streamer: two instances (LINE_GAP=2 and LINE_GAP=0) share stimulus.
// Both are checked every cycle against a pixel-index model, plus literal timing/value expectations.
module tb_gray_frame_streamer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          start = 1'b0;
    logic          hold = 1'b0;

    logic        busy [2];
    logic        done [2];
    logic        gv   [2];
    logic [7:0]  gray [2];
    logic [31:0] prow [2];
    logic [31:0] pcol [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .LINE_GAP(2)) dut_gap2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .hold(hold), .busy(busy[0]), .done(done[0]), .gray_valid(gv[0]),
        .gray(gray[0]), .pix_row(prow[0]), .pix_col(pcol[0]));

    gray_frame_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .LINE_GAP(0)) dut_gap0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .hold(hold), .busy(busy[1]), .done(done[1]), .gray_valid(gv[1]),
        .gray(gray[1]), .pix_row(prow[1]), .pix_col(pcol[1]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d] at cycle %0d: got %0d, expected %0d", name, k, cyc, act, exp);
        end
    endtask

    // Model: frame array plus pixel index, remaining gap cycles and a pending-done flag.
    logic [7:0] fmem [2][N];
    int   m_pos [2];
    int   m_gap [2];
    bit   m_flush [2];
    bit   e_busy [2];
    bit   e_done [2];
    bit   e_valid [2];
    logic [7:0] e_gray [2];
    int   e_row [2];
    int   e_col [2];
    bit   model_live = 1'b0;

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_busy[k] = 0; e_done[k] = 0; e_valid[k] = 0; e_gray[k] = 8'd0;
                e_row[k] = 0; e_col[k] = 0; m_flush[k] = 0; m_gap[k] = 0; m_pos[k] = 0;
            end else begin
                if (wr_en && !e_busy[k] && int'(wr_addr) < N) fmem[k][wr_addr] = wr_data;
                e_done[k] = 0;
                e_valid[k] = 0;
                if (m_flush[k]) begin
                    m_flush[k] = 0; e_busy[k] = 0; e_done[k] = 1;
                end else if (!e_busy[k]) begin
                    if (start) begin e_busy[k] = 1; m_pos[k] = 0; m_gap[k] = 0; end
                end else if (m_gap[k] > 0) begin
                    m_gap[k]--;
                end else if (!hold) begin
                    e_valid[k] = 1;
                    e_gray[k]  = fmem[k][m_pos[k]];
                    e_row[k]   = m_pos[k] / W;
                    e_col[k]   = m_pos[k] % W;
                    m_pos[k]++;
                    if (m_pos[k] == N) m_flush[k] = 1;
                    else if (m_pos[k] % W == 0) m_gap[k] = (k == 0) ? 2 : 0;
                end
            end
        end
        if (rst) model_live = 1'b1;
    end

    // Per-cycle comparison against the model, plus capture of the valid pixels for literal checks.
    int vval [2][64];
    int vt   [2][64];
    int vn   [2] = '{0, 0};
    int dt   [2] = '{0, 0};
    int dcount [2] = '{0, 0};

    always @(negedge clk) begin
        if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                chk("busy", k, 32'(busy[k]), 32'(e_busy[k]));
                chk("done", k, 32'(done[k]), 32'(e_done[k]));
                chk("gray_valid", k, 32'(gv[k]), 32'(e_valid[k]));
                chk("gray", k, 32'(gray[k]), 32'(e_gray[k]));
                chk("pix_row", k, prow[k], e_row[k]);
                chk("pix_col", k, pcol[k], e_col[k]);
                if (gv[k] === 1'b1 && vn[k] < 64) begin
                    vval[k][vn[k]] = int'(gray[k]);
                    vt[k][vn[k]] = cyc;
                    vn[k]++;
                end
                if (done[k] === 1'b1) begin
                    dt[k] = cyc;
                    dcount[k]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int ts = 0;

    task automatic clear_capture();
        for (int k = 0; k < 2; k++) begin vn[k] = 0; dcount[k] = 0; end
    endtask

    task automatic launch();
        clear_capture();
        start = 1'b1;
        ts = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while (!(dcount[0] > 0 && dcount[1] > 0) && n < 100) begin step(); n++; end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL %s_timeout: done pulses got %0d/%0d, expected 1/1 within 100 cycles",
                     name, dcount[0], dcount[1]);
        end
    endtask

    task automatic wait_pixel(input string name, input int v);
        int n = 0;
        while (!(gv[0] === 1'b1 && int'(gray[0]) == v) && n < 60) begin step(); n++; end
        tests++;
        if (n >= 60) begin
            fails++;
            $display("FAIL %s: pixel value got none, expected %0d within 60 cycles", name, v);
        end
    endtask

    task automatic check_ramp(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_count"}, k, vn[k], N);
            for (int i = 0; i < N; i++) chk({name, "_value"}, k, vval[k][i], i);
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;

        // Load ramp: address n holds value n.
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        step();

        // Plain stream: timing of each pixel relative to the first, and done placement.
        launch();
        wait_frame("ramp");
        check_ramp("ramp");
        chk("first_valid_latency", 0, vt[0][0] - ts, 2);
        chk("first_valid_latency", 1, vt[1][0] - ts, 2);
        for (int i = 0; i < N; i++) begin
            chk("gap2_offset", 0, vt[0][i] - vt[0][0], i + 2 * (i / W));
            chk("gap0_offset", 1, vt[1][i] - vt[1][0], i);
        end
        chk("done_offset", 0, dt[0] - vt[0][0], 16);
        chk("done_offset", 1, dt[1] - vt[1][0], 12);
        chk("done_pulses", 0, dcount[0], 1);
        chk("done_pulses", 1, dcount[1], 1);

        // hold for three cycles right after pixel 5.
        launch();
        wait_pixel("hold_wait", 5);
        hold = 1'b1;
        step(); step(); step();
        hold = 1'b0;
        wait_frame("hold");
        check_ramp("hold");
        chk("hold_pause", 0, vt[0][6] - vt[0][5], 4);

        // Out-of-range write while idle, then a write while busy: both dropped.
        wr_en = 1'b1; wr_addr = AW'(12); wr_data = 8'hAA;
        step();
        wr_en = 1'b0;
        launch();
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'hEE;
        step();
        wr_en = 1'b0;
        wait_frame("busy_write");
        check_ramp("busy_write");
        launch();
        wait_frame("restream");
        check_ramp("restream");

        // Write and start together: the new value is the first pixel.
        clear_capture();
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h55; start = 1'b1;
        step();
        wr_en = 1'b0; start = 1'b0;
        wait_frame("wr_start");
        chk("wr_start_first", 0, vval[0][0], 32'h55);
        chk("wr_start_first", 1, vval[1][0], 32'h55);
        chk("wr_start_second", 0, vval[0][1], 1);
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h00;
        step();
        wr_en = 1'b0;

        // Reset mid-frame after pixel 6: outputs clear, no done, next frame replays intact.
        launch();
        wait_pixel("rst_wait", 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", 0, 32'(gv[0]), 0);
        chk("rst_gray", 0, 32'(gray[0]), 0);
        chk("rst_row", 0, prow[0], 0);
        chk("rst_col", 0, pcol[0], 0);
        chk("rst_busy", 0, 32'(busy[0]), 0);
        for (int i = 0; i < 10; i++) step();
        chk("rst_no_done", 0, dcount[0], 0);
        chk("rst_no_done", 1, dcount[1], 0);
        launch();
        wait_frame("after_rst");
        check_ramp("after_rst");

        // Constant frame of 90, as fed to a mean filter.
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'd90;
            step();
        end
        wr_en = 1'b0;
        launch();
        wait_frame("const90");
        for (int k = 0; k < 2; k++) begin
            chk("const90_count", k, vn[k], N);
            for (int i = 0; i < N; i++) chk("const90_value", k, vval[k][i], 90);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck, expected completion before 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/gray_frame_streamer.md
# gray_frame_streamer

Frame-buffered raster source for the grayscale filter chain (3x3 mean and similar window filters). It holds one IMAGE_WIDTH x IMAGE_HEIGHT 8-bit frame, loaded through a simple write port. On `start` it replays the frame as a `gray_valid`/`gray` pixel stream in raster order, with a configurable idle gap between rows and an optional pause input. Its output drives the `gray_valid`/`gray` inputs of the window filters directly, which lets benches and the demo top feed the filter chain deterministic frames.

## Interface
- IMAGE_WIDTH, 320, pixels per row (>=2)
- IMAGE_HEIGHT, 240, rows per frame (>=2)
- LINE_GAP, 4, idle cycles inserted between consecutive rows (0 allowed)
- ADDR_W, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), frame address width (derived localparam, not overridable)
- clk  in  1  sole clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  frame-load write strobe
- wr_addr  in  ADDR_W  linear address, row*IMAGE_WIDTH+col
- wr_data  in  8  pixel value to store
- start  in  1  begin streaming one frame (single-cycle pulse or level)
- hold  in  1  pause: no new pixel issued while high
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after the final pixel
- gray_valid  out  1  pixel strobe
- gray  out  8  pixel value
- pix_row  out  32  row of current `gray`, zero-extended
- pix_col  out  32  column of current `gray`, zero-extended

## Operation
- Storage: single-port-write, synchronous-read RAM of IMAGE_WIDTH*IMAGE_HEIGHT bytes, 1-cycle read latency. Contents are not cleared by `rst`.
- Writes are accepted only when busy=0 and wr_addr < IMAGE_WIDTH*IMAGE_HEIGHT; otherwise they are silently dropped.
- FSM states: IDLE, STREAM, GAP, FLUSH.
- IDLE: start=1 -> STREAM, with row=0 and col=0. start is ignored in every other state.
- STREAM: each cycle with hold=0 issues a read at row*IMAGE_WIDTH+col and advances col. A cycle with hold=1 issues nothing and freezes row and col.
- At col=IMAGE_WIDTH-1 with the read issued: col wraps to 0 and row increments.
  - If that was the last row -> FLUSH.
  - Else if LINE_GAP>0 -> GAP.
  - Else -> stay in STREAM (back-to-back rows).
- GAP: counts LINE_GAP cycles, then -> STREAM. hold is ignored in GAP.
- FLUSH: one cycle while the final read data emerges -> IDLE, with done pulsed.
- Output register: the cycle after a read is issued, gray_valid=1, gray=RAM data, and pix_row/pix_col = the coordinates of that read. On cycles with no issued read, gray_valid=0 and gray/pix_row/pix_col hold their last values.
- Simultaneous wr_en and start in IDLE: the write completes, then streaming starts. The first read occurs a cycle later, so the new data is visible.
- Reset mid-frame: state returns to IDLE immediately, the partial frame is abandoned, and no done is issued.

## Timing
- Reset values: busy=0, done=0, gray_valid=0, gray=0, pix_row=0, pix_col=0, FSM state IDLE.
- start sampled at edge T:
  - busy=1 from T+1.
  - First read issued in cycle T+1.
  - First gray_valid=1 in cycle T+2.
- Steady state: one pixel per cycle within a row.
- hold sampled high at edge E: gray_valid is 0 in the cycle after E (1-cycle pause latency).
- Frame length with no hold: W*H + LINE_GAP*(H-1) issue cycles. There is no gap after the last row.
- Final gray_valid cycle F: busy=0 and done=1 in cycle F+1. done is exactly one cycle wide. A new start is accepted from cycle F+1.
- gray_valid never asserts while busy=0, except in the single cycle where done=1? No: the final pixel's valid cycle F still has busy=1.

## Test plan
- Load ramp with W=4, H=3, LINE_GAP=2 (addr n -> data n), then pulse start -> 12 valid pixels with values 0..11 in raster order. Two idle cycles after values 3 and 7. done in the cycle after value 11. Total 16 cycles from first valid to done.
- LINE_GAP=0 on the same frame -> 12 consecutive valid cycles. pix_col wraps 3->0 and pix_row steps 0->1->2.
- hold high for 3 cycles after pixel 5 -> exactly 3 invalid cycles. Pixel 6 follows, with no duplicated or skipped values.
- Write to addr 12 (out of range) and a write during busy -> stored frame unchanged. Re-stream still yields 0..11.
- Assert rst after pixel 6 -> all outputs 0 next cycle, no done. The next start replays 0..11 from pixel 0 with RAM intact.
- Feed the stream to the 3x3 mean filter using a constant frame of 90 -> every filter output is 90.
